// File: rtl/mask_encoder32_5.sv
`default_nettype none
// ============================================================================
// Module      : mask_encoder32_5
// Description : Sequential priority encoder. Accepts an N-bit mask and emits
//               the binary index of every set bit, one per valid/ready beat,
//               lowest bit first (HI_FIRST=0) or highest bit first
//               (HI_FIRST=1). The inverse of the 5-to-32 one-hot decoder used
//               for register-file write enables.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1   rising-edge clock
//   reset      in   1   asynchronous, active-high reset
//   in_valid   in   1   in_mask is valid
//   in_ready   out  1   block can accept a mask (IDLE and no flush)
//   in_mask    in   N   mask to encode
//   flush      in   1   synchronous abort; discards pending bits
//   out_valid  out  1   out_idx is valid
//   out_ready  in   1   consumer accepts out_idx
//   out_idx    out  IW  index of the current set bit
//   out_last   out  1   current beat is the last set bit of the mask
//   zero_err   out  1   one-cycle pulse: accepted mask was all zeros
//   busy       out  1   high while emitting beats
// ============================================================================
module mask_encoder32_5 #(
  parameter int N        = 32,
  parameter int IW       = $clog2(N),
  parameter bit HI_FIRST = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_mask,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_idx,
  output logic          out_last,
  output logic          zero_err,
  output logic          busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t        state_q,     state_d;
  logic [N-1:0]  pending_q,   pending_d;
  logic          out_valid_q, out_valid_d;
  logic [IW-1:0] out_idx_q,   out_idx_d;
  logic          out_last_q,  out_last_d;
  logic          zero_err_q,  zero_err_d;

  // pending with the bit of the current beat removed
  logic [N-1:0]  pending_clr;
  // vector the next beat is derived from: the fresh mask in IDLE,
  // otherwise what remains after the current beat is consumed
  logic [N-1:0]  enc_src;
  logic [IW-1:0] enc_idx;
  logic          enc_single;

  assign pending_clr = pending_q & ~(N'(1) << out_idx_q);
  assign enc_src     = (state_q == IDLE) ? in_mask : pending_clr;
  // exactly one bit set: non-zero and clearing the lowest set bit leaves zero
  assign enc_single  = (enc_src != '0) && ((enc_src & (enc_src - N'(1))) == '0);

  // Priority encoder; the last assignment in loop order wins, so the loop
  // direction selects which end of the mask has priority.
  generate
    if (HI_FIRST) begin : g_hi_first
      always_comb begin
        enc_idx = '0;
        for (int i = 0; i < N; i++) begin
          if (enc_src[i]) enc_idx = IW'(i);
        end
      end
    end else begin : g_lo_first
      always_comb begin
        enc_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
          if (enc_src[i]) enc_idx = IW'(i);
        end
      end
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    zero_err_d  = 1'b0;

    if (flush) begin
      // flush beats any load or handshake this cycle; a handshaking beat is
      // treated as consumed and nothing further is emitted
      state_d     = IDLE;
      pending_d   = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else if (state_q == IDLE) begin
      if (in_valid) begin
        pending_d = in_mask;
        if (in_mask == '0) begin
          zero_err_d = 1'b1;
        end else begin
          state_d     = EMIT;
          out_valid_d = 1'b1;
          out_idx_d   = enc_idx;
          out_last_d  = enc_single;
        end
      end
    end else if (out_valid_q && out_ready) begin
      pending_d = pending_clr;
      if (out_last_q) begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end else begin
        out_idx_d  = enc_idx;
        out_last_d = enc_single;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      zero_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      zero_err_q  <= zero_err_d;
    end
  end

  // a flush in IDLE must not let a mask slip in alongside it
  assign in_ready  = (state_q == IDLE) && !flush;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign zero_err  = zero_err_q;
  assign busy      = (state_q == EMIT);

endmodule
`default_nettype wire
